// File: rtl/sum_normalizer_64_pkg.sv
// Shared constants, state type and lane-scaling helper for the softmax normaliser.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sum_normalizer_64_pkg;

    localparam int DW              = 16;
    localparam int FRAC            = 10;
    localparam int LANES           = 64;
    localparam int GROUPS          = 4;
    localparam int LANES_PER_GROUP = LANES / GROUPS;

    // Reciprocal numerator 2^(2*FRAC) needs 2*FRAC+1 bits; one quotient bit per step.
    localparam int QW        = 2 * FRAC + 1;
    localparam int DIV_STEPS = QW;

    localparam logic [QW-1:0] RECIP_NUMER = {1'b1, {(2 * FRAC){1'b0}}};
    localparam logic [DW-1:0] SAT_MAX     = {DW{1'b1}};

    localparam logic [1:0] LM_64 = 2'b00;
    localparam logic [1:0] LM_32 = 2'b01;
    localparam logic [1:0] LM_16 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_MUL,
        ST_OUT
    } state_t;

    // out = min((num * recip) >> FRAC, max), truncating the dropped fraction.
    function automatic logic [DW-1:0] scale_lane(input logic [DW-1:0] num,
                                                 input logic [DW-1:0] recip);
        logic [2*DW-1:0] prod;
        prod = {{DW{1'b0}}, num} * {{DW{1'b0}}, recip};
        if (|prod[2*DW-1:DW+FRAC]) begin
            scale_lane = SAT_MAX;
        end else begin
            scale_lane = prod[DW+FRAC-1:FRAC];
        end
    endfunction

endpackage

// File: rtl/sum_normalizer_64_recip_div_seq.sv
// Restoring radix-2 divider: quotient = numer / divisor, one bit per enabled cycle.
// Latency: first step on the start edge, o_done pulses after DIV_STEPS enabled edges.
// Backpressure: none; i_en low freezes all state.
module recip_div_seq
    import sum_normalizer_64_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_start,
    input  logic [QW-1:0] i_numer,
    input  logic [DW-1:0] i_divisor,
    output logic          o_done,
    output logic [DW-1:0] o_quot,
    output logic          o_sat,
    output logic          o_div0
);

    localparam logic [4:0] CNT_INIT = 5'(DIV_STEPS - 1);

    logic [DW-1:0] r_div;
    logic [DW-1:0] r_rem;
    logic [QW-1:0] r_quo;
    logic [4:0]    r_cnt;
    logic          r_done;
    logic          r_div0;

    logic [DW-1:0] w_d;
    logic [DW-1:0] w_rem_src;
    logic [QW-1:0] w_quo_src;
    logic [DW:0]   w_trial;
    logic [DW:0]   w_diff;
    logic          w_fit;
    logic [DW-1:0] w_rem_nxt;
    logic [QW-1:0] w_quo_nxt;

    // One restoring step; on start it runs on fresh operands so the first bit lands on the start edge.
    always_comb begin
        w_d       = i_start ? i_divisor : r_div;
        w_rem_src = i_start ? '0 : r_rem;
        w_quo_src = i_start ? i_numer : r_quo;
        w_trial   = {w_rem_src, w_quo_src[QW-1]};
        w_diff    = w_trial - {1'b0, w_d};
        w_fit     = (w_trial >= {1'b0, w_d});
        w_rem_nxt = w_fit ? w_diff[DW-1:0] : w_trial[DW-1:0];
        w_quo_nxt = {w_quo_src[QW-2:0], w_fit};
    end

    // Iteration state: the numerator shifts out of r_quo as quotient bits shift in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_div  <= i_divisor;
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_cnt  <= CNT_INIT;
                r_done <= 1'b0;
                r_div0 <= (i_divisor == '0);
            end else if (r_cnt != '0) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_cnt  <= r_cnt - 5'd1;
                r_done <= (r_cnt == 5'd1);
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    // A zero divisor makes every trial fit, so the quotient is all ones and saturates.
    assign o_done = r_done;
    assign o_quot = r_quo[DW-1:0];
    assign o_sat  = |r_quo[QW-1:DW];
    assign o_div0 = r_div0;

endmodule

// File: rtl/sum_normalizer_64.sv
// Softmax tail: per-group reciprocal of the adder-tree sums, then scales all 64 lanes.
// Latency: o_valid rises on the 2*FRAC+3rd enabled edge counting the accept edge.
// Backpressure: one vector in flight; o_ready only in IDLE, result held while i_ready is low.
module sum_normalizer_64
    import sum_normalizer_64_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_length_mode,
    input  logic [DW-1:0]         i_sum64_0,
    input  logic [DW-1:0]         i_sum32_0,
    input  logic [DW-1:0]         i_sum32_1,
    input  logic [DW-1:0]         i_sum16_0,
    input  logic [DW-1:0]         i_sum16_1,
    input  logic [DW-1:0]         i_sum16_2,
    input  logic [DW-1:0]         i_sum16_3,
    input  logic [LANES*DW-1:0]   i_num_flat,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LANES*DW-1:0]   o_out_flat,
    output logic                  o_div0
);

    state_t r_state;
    state_t w_state_nxt;

    logic                w_accept;
    logic                w_consume;
    logic [DW-1:0]       w_grp_sum [GROUPS];
    logic [GROUPS-1:0]   w_done;
    logic [GROUPS-1:0]   w_sat;
    logic [GROUPS-1:0]   w_div0;
    logic [DW-1:0]       w_quot    [GROUPS];
    logic [DW-1:0]       w_recip   [GROUPS];
    logic [LANES*DW-1:0] w_scaled;

    logic [LANES*DW-1:0] r_num;
    logic [LANES*DW-1:0] r_out;
    logic                r_div0;

    assign o_ready    = (r_state == ST_IDLE);
    assign o_valid    = (r_state == ST_OUT);
    assign o_out_flat = r_out;
    assign o_div0     = r_div0;

    assign w_accept  = i_en && i_valid && o_ready;
    assign w_consume = i_en && o_valid && i_ready;

    // Map the mode's sums onto four lane groups; unused encodings behave as 64-mode.
    always_comb begin
        w_grp_sum[0] = i_sum64_0;
        w_grp_sum[1] = i_sum64_0;
        w_grp_sum[2] = i_sum64_0;
        w_grp_sum[3] = i_sum64_0;
        case (i_length_mode)
            LM_32: begin
                w_grp_sum[0] = i_sum32_0;
                w_grp_sum[1] = i_sum32_0;
                w_grp_sum[2] = i_sum32_1;
                w_grp_sum[3] = i_sum32_1;
            end
            LM_16: begin
                w_grp_sum[0] = i_sum16_0;
                w_grp_sum[1] = i_sum16_1;
                w_grp_sum[2] = i_sum16_2;
                w_grp_sum[3] = i_sum16_3;
            end
            default: ;
        endcase
    end

    // Duplicate groups in 64/32-mode see the same divisor, so their results are identical.
    for (genvar g = 0; g < GROUPS; g++) begin : g_div
        recip_div_seq u_div (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .i_start   (w_accept),
            .i_numer   (RECIP_NUMER),
            .i_divisor (w_grp_sum[g]),
            .o_done    (w_done[g]),
            .o_quot    (w_quot[g]),
            .o_sat     (w_sat[g]),
            .o_div0    (w_div0[g])
        );
        assign w_recip[g] = w_sat[g] ? SAT_MAX : w_quot[g];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_scaled[k*DW +: DW] = scale_lane(r_num[k*DW +: DW], w_recip[k / LANES_PER_GROUP]);
    end

    // All dividers start together under the same enable, so they finish together.
    a_lockstep: assert property (@(posedge i_clk) disable iff (i_rst)
                                 (w_done == {GROUPS{w_done[0]}}));

    // State register; reset beats the enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: divide until group 0 reports done, one scaling cycle, then hold for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_DIV;
            ST_DIV:  if (w_done[0]) w_state_nxt = ST_MUL;
            ST_MUL:                 w_state_nxt = ST_OUT;
            ST_OUT:  if (w_consume) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch numerators on accept; register scaled lanes and the zero-sum flag in the MUL cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num  <= '0;
            r_out  <= '0;
            r_div0 <= 1'b0;
        end else if (i_en) begin
            if (w_accept) begin
                r_num <= i_num_flat;
            end
            if (r_state == ST_MUL) begin
                r_out  <= w_scaled;
                r_div0 <= |w_div0;
            end
        end
    end

endmodule
